// File: rtl/grf_wport_arb_if.sv
// grf_wport_arb_if
// Bundles every signal between the GRF write-port arbiter and its clients.
//   master : driven by the pipeline side. It supplies the writeback request
//            (wb_*), the multiply/divide result (md_*) and the decode source
//            registers (rs/rt). It observes the handshakes, the GRF write
//            port, the busy flags and the queue occupancy.
//   slave  : the arbiter itself, with the opposite directions.
interface grf_wport_arb_if;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] wb_pc;
    logic        wb_ready;

    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic [31:0] md_pc;
    logic        md_ready;

    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wpc;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_busy;
    logic        rt_busy;
    logic [1:0]  pending;

    modport master (
        output wb_valid, wb_addr, wb_data, wb_pc,
        output md_valid, md_addr, md_data, md_pc,
        output rs, rt,
        input  wb_ready, md_ready,
        input  we, waddr, wdata, wpc,
        input  rs_busy, rt_busy, pending
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wb_pc,
        input  md_valid, md_addr, md_data, md_pc,
        input  rs, rt,
        output wb_ready, md_ready,
        output we, waddr, wdata, wpc,
        output rs_busy, rt_busy, pending
    );
endinterface

// File: rtl/grf_wport_arb.sv
// grf_wport_arb
// Shares the single GRF write port between the pipeline writeback stage and
// the multiply/divide unit. Writeback has priority and is never queued. MD
// results go through a 2-entry FIFO and are written when writeback is idle,
// or forcibly once the head has been denied STARVE_LIMIT consecutive cycles.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-high reset, empties the FIFO
//   bus   : grf_wport_arb_if.slave (writeback/MD requests, GRF write port,
//           rs/rt busy flags and queue occupancy)
module grf_wport_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    grf_wport_arb_if.slave  bus
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [4:0]    q_addr [2];
    logic [31:0]   q_data [2];
    logic [31:0]   q_pc   [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic [SW-1:0] starve_cnt;

    logic          starved;
    logic          head_grant;
    logic          wb_grant;
    logic          enq;
    logic [1:0]    entry_valid;

    // Grant decision. The head wins when writeback is idle or when it has
    // been starved long enough; in the latter case writeback is stalled.
    // md_ready depends only on registered occupancy, so a result accepted
    // this cycle can never be written before the next one.
    always_comb begin
        starved      = (starve_cnt == SW'(STARVE_LIMIT));
        head_grant   = (count != 2'd0) && (!bus.wb_valid || starved);
        wb_grant     = bus.wb_valid && !head_grant && !reset;
        enq          = bus.md_valid && (count != 2'd2) && (bus.md_addr != 5'd0);
        bus.md_ready = (count != 2'd2);
        bus.wb_ready = !(bus.wb_valid && head_grant);
        bus.pending  = count;

        bus.we    = 1'b0;
        bus.waddr = 5'd0;
        bus.wdata = 32'd0;
        bus.wpc   = 32'd0;
        if (head_grant) begin
            bus.we    = 1'b1;
            bus.waddr = q_addr[rd_ptr];
            bus.wdata = q_data[rd_ptr];
            bus.wpc   = q_pc[rd_ptr];
        end else if (wb_grant) begin
            bus.we    = (bus.wb_addr != 5'd0);
            bus.waddr = bus.wb_addr;
            bus.wdata = bus.wb_data;
            bus.wpc   = bus.wb_pc;
        end
    end

    // Scoreboard hazard flags. The entry being written this cycle is still
    // reported busy, because decode reads the GRF only after the write lands.
    always_comb begin
        bus.rs_busy = 1'b0;
        bus.rt_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            entry_valid[i] = (count == 2'd2) || ((count == 2'd1) && (rd_ptr == 1'(i)));
            if (entry_valid[i] && (bus.rs != 5'd0) && (q_addr[i] == bus.rs)) begin
                bus.rs_busy = 1'b1;
            end
            if (entry_valid[i] && (bus.rt != 5'd0) && (q_addr[i] == bus.rt)) begin
                bus.rt_busy = 1'b1;
            end
        end
    end

    // FIFO storage, pointers and occupancy. Results for r0 are accepted but
    // dropped, since enq already excludes them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                q_addr[i] <= 5'd0;
                q_data[i] <= 32'd0;
                q_pc[i]   <= 32'd0;
            end
        end else begin
            if (enq) begin
                q_addr[wr_ptr] <= bus.md_addr;
                q_data[wr_ptr] <= bus.md_data;
                q_pc[wr_ptr]   <= bus.md_pc;
                wr_ptr         <= ~wr_ptr;
            end
            if (head_grant) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({enq, head_grant})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Counts consecutive cycles the head has waited behind writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if ((count == 2'd0) || head_grant) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_grf_wport_arb.sv
// tb_grf_wport_arb
// Directed bench for grf_wport_arb. Every GRF write the bench expects is
// pushed into a queue in its hand-computed order; an independent monitor
// pops and compares whenever the DUT asserts we. Handshake, occupancy and
// busy flags are checked inline against hand-computed constants.
module tb_grf_wport_arb;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } wr_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    wr_t  expq[$];

    grf_wport_arb_if bus ();

    grf_wport_arb #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Long-contention scenario: expected wb_ready and pending per cycle
    logic exp_wbr_c  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   exp_pend_c [12] = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 1, 1, 0};

    // Hazard scenario: rs/rt inputs and expected busy flags / wb_ready
    logic [4:0] rs_d     [7] = '{5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 5'd9, 5'd9};
    logic [4:0] rt_d     [7] = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd0, 5'd0};
    logic       exp_rs_d [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_rt_d [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_wbr_d[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic wbv, input logic [4:0] wba, input logic [31:0] wbd, input logic [31:0] wbp,
                                 input logic mdv, input logic [4:0] mda, input logic [31:0] mdd, input logic [31:0] mdp);
        bus.wb_valid = wbv;
        bus.wb_addr  = wba;
        bus.wb_data  = wbd;
        bus.wb_pc    = wbp;
        bus.md_valid = mdv;
        bus.md_addr  = mda;
        bus.md_data  = mdd;
        bus.md_pc    = mdp;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.pc   = p;
        expq.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every GRF write must match the next expected one
    initial begin
        wr_t got;
        wr_t want;
        forever begin
            @(negedge clk);
            if (bus.we === 1'b1) begin
                got.addr = bus.waddr;
                got.data = bus.wdata;
                got.pc   = bus.wpc;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected write: addr=%0d data=0x%0h pc=0x%0h, none expected at %0t",
                             got.addr, got.data, got.pc, $time);
                end else begin
                    want = expq.pop_front();
                    checkOutput("write addr", 32'(got.addr), 32'(want.addr));
                    checkOutput("write data", got.data, want.data);
                    checkOutput("write pc", got.pc, want.pc);
                end
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        applyStimulus(1'b1, 5'd7, 32'h77, 32'h70, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("reset we", 32'(bus.we), 32'd0);
        checkOutput("reset wb_ready", 32'(bus.wb_ready), 32'd1);
        checkOutput("reset md_ready", 32'(bus.md_ready), 32'd1);
        checkOutput("reset pending", 32'(bus.pending), 32'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);

        // Single MD result on an idle port is written the following cycle
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 32'h100);
        expectWrite(5'd5, 32'h1234, 32'h100);
        #2;
        checkOutput("A md_ready", 32'(bus.md_ready), 32'd1);
        checkOutput("A no bypass we", 32'(bus.we), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("A pending 1", 32'(bus.pending), 32'd1);
        checkOutput("A we", 32'(bus.we), 32'd1);
        tick();
        #2;
        checkOutput("A pending 0", 32'(bus.pending), 32'd0);

        // r0 destinations: MD result dropped, writeback accepted without write
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 32'h104);
        #2;
        checkOutput("B md_ready r0", 32'(bus.md_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 5'd0, 32'hBEEF, 32'h108, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("B pending r0", 32'(bus.pending), 32'd0);
        checkOutput("B wb r0 we", 32'(bus.we), 32'd0);
        checkOutput("B wb r0 ready", 32'(bus.wb_ready), 32'd1);
        tick();
        applyStimulus(1'b1, 5'd10, 32'hAAAA, 32'h200, 1'b0, 5'd0, 32'd0, 32'd0);
        expectWrite(5'd10, 32'hAAAA, 32'h200);
        #2;
        checkOutput("B wb we", 32'(bus.we), 32'd1);
        tick();

        // Continuous writeback starving two queued MD results
        for (int i = 0; i < 5; i++) expectWrite(5'd8, 32'(32'h8000 + i), 32'(32'h3000 + i));
        expectWrite(5'd3, 32'h33, 32'h333);
        for (int i = 5; i < 9; i++) expectWrite(5'd8, 32'(32'h8000 + i), 32'(32'h3000 + i));
        expectWrite(5'd4, 32'h44, 32'h444);
        expectWrite(5'd8, 32'h8009, 32'h3009);
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 0)
                applyStimulus(1'b1, 5'd8, 32'(32'h8000 + n), 32'(32'h3000 + n), 1'b1, 5'd3, 32'h33, 32'h333);
            else if (k == 1)
                applyStimulus(1'b1, 5'd8, 32'(32'h8000 + n), 32'(32'h3000 + n), 1'b1, 5'd4, 32'h44, 32'h444);
            else
                applyStimulus(1'b1, 5'd8, 32'(32'h8000 + n), 32'(32'h3000 + n), 1'b0, 5'd0, 32'd0, 32'd0);
            #2;
            checkOutput($sformatf("C wb_ready k%0d", k), 32'(bus.wb_ready), 32'(exp_wbr_c[k]));
            checkOutput($sformatf("C pending k%0d", k), 32'(bus.pending), 32'(exp_pend_c[k]));
            checkOutput($sformatf("C md_ready k%0d", k), 32'(bus.md_ready), (exp_pend_c[k] != 2) ? 32'd1 : 32'd0);
            if (exp_wbr_c[k]) n++;
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("C drained", 32'(bus.pending), 32'd0);
        tick();

        // Hazard flags while r9 waits behind a writeback to r0
        expectWrite(5'd9, 32'h99, 32'h999);
        for (int k = 0; k < 7; k++) begin
            if (k == 0)
                applyStimulus(1'b1, 5'd0, 32'h5555, 32'h400, 1'b1, 5'd9, 32'h99, 32'h999);
            else
                applyStimulus(1'b1, 5'd0, 32'h5555, 32'h400, 1'b0, 5'd0, 32'd0, 32'd0);
            bus.rs = rs_d[k];
            bus.rt = rt_d[k];
            #2;
            checkOutput($sformatf("D rs_busy k%0d", k), 32'(bus.rs_busy), 32'(exp_rs_d[k]));
            checkOutput($sformatf("D rt_busy k%0d", k), 32'(bus.rt_busy), 32'(exp_rt_d[k]));
            checkOutput($sformatf("D wb_ready k%0d", k), 32'(bus.wb_ready), 32'(exp_wbr_d[k]));
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        bus.rs = 5'd0;
        bus.rt = 5'd0;

        // Enqueue and dequeue in the same cycle keeps pending at 1, in order
        expectWrite(5'd11, 32'hB1, 32'h500);
        expectWrite(5'd12, 32'hB2, 32'h504);
        expectWrite(5'd13, 32'hB3, 32'h508);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd11, 32'hB1, 32'h500);
        #2;
        checkOutput("E pending k0", 32'(bus.pending), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd12, 32'hB2, 32'h504);
        #2;
        checkOutput("E pending k1", 32'(bus.pending), 32'd1);
        checkOutput("E md_ready k1", 32'(bus.md_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd13, 32'hB3, 32'h508);
        #2;
        checkOutput("E pending k2", 32'(bus.pending), 32'd1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("E pending k3", 32'(bus.pending), 32'd1);
        tick();
        #2;
        checkOutput("E pending k4", 32'(bus.pending), 32'd0);
        tick();

        // Full queue wiped by a reset pulse between clock edges
        applyStimulus(1'b1, 5'd0, 32'h6666, 32'h600, 1'b1, 5'd14, 32'hE1, 32'h604);
        tick();
        applyStimulus(1'b1, 5'd0, 32'h6666, 32'h600, 1'b1, 5'd15, 32'hE2, 32'h608);
        tick();
        applyStimulus(1'b1, 5'd0, 32'h6666, 32'h600, 1'b0, 5'd0, 32'd0, 32'd0);
        bus.rs = 5'd14;
        bus.rt = 5'd15;
        #2;
        checkOutput("F pending full", 32'(bus.pending), 32'd2);
        checkOutput("F md_ready full", 32'(bus.md_ready), 32'd0);
        checkOutput("F rs_busy full", 32'(bus.rs_busy), 32'd1);
        checkOutput("F rt_busy full", 32'(bus.rt_busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("F reset pending", 32'(bus.pending), 32'd0);
        checkOutput("F reset md_ready", 32'(bus.md_ready), 32'd1);
        checkOutput("F reset rs_busy", 32'(bus.rs_busy), 32'd0);
        checkOutput("F reset rt_busy", 32'(bus.rt_busy), 32'd0);
        checkOutput("F reset wb_ready", 32'(bus.wb_ready), 32'd1);
        checkOutput("F reset we", 32'(bus.we), 32'd0);
        reset = 1'b0;
        tick();
        bus.rs = 5'd0;
        bus.rt = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 5'd16, 32'hF0, 32'h700);
        expectWrite(5'd16, 32'hF0, 32'h700);
        #2;
        checkOutput("F post pending", 32'(bus.pending), 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
        #2;
        checkOutput("F post we", 32'(bus.we), 32'd1);
        checkOutput("F post waddr", 32'(bus.waddr), 32'd16);
        tick();
        tick();

        checkOutput("expected writes left", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
